// File: rtl/elastic_buffer_skp_ctrl_if.sv
// Buffer-head / decoder-side bundle for the elastic buffer read controller.
// slave = controller side, master = buffer/decoder (or bench) side.
interface elastic_buffer_skp_ctrl_if #(
  parameter int DATA_WIDTH   = 10,
  parameter int BUFFER_DEPTH = 16
);
  localparam int FILL_W = $clog2(BUFFER_DEPTH) + 1;

  logic                  buffer_mode;
  logic [FILL_W-1:0]     fill_level;
  logic [DATA_WIDTH-1:0] head_data;
  logic [DATA_WIDTH-1:0] head_next_data;
  logic [1:0]            pop_cnt;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  out_valid;
  logic                  skp_added_removed;
  logic                  skp_added;
  logic                  skp_removed;
  logic                  underflow;
  logic                  overflow;

  modport slave (
    input  buffer_mode, fill_level, head_data, head_next_data,
    output pop_cnt, data_out, out_valid, skp_added_removed,
           skp_added, skp_removed, underflow, overflow
  );

  modport master (
    output buffer_mode, fill_level, head_data, head_next_data,
    input  pop_cnt, data_out, out_valid, skp_added_removed,
           skp_added, skp_removed, underflow, overflow
  );
endinterface

// File: rtl/elastic_buffer_skp_ctrl.sv
// Elastic buffer read-side controller: pops 0/1/2 symbols per cycle and
// duplicates or drops one SKP per ordered set to re-centre occupancy.
module elastic_buffer_skp_ctrl #(
  parameter int               DATA_WIDTH    = 10,
  parameter int               BUFFER_DEPTH  = 16,
  parameter int               LOW_WM        = 6,
  parameter int               HIGH_WM       = 10,
  parameter int               EMPTY_HIGH_WM = 4,
  parameter logic [DATA_WIDTH-1:0] COM_N    = 10'h0FA,
  parameter logic [DATA_WIDTH-1:0] COM_P    = 10'h305,
  parameter logic [DATA_WIDTH-1:0] SKP_N    = 10'h0F4,
  parameter logic [DATA_WIDTH-1:0] SKP_P    = 10'h30B
) (
  input logic clk_read,
  input logic rst_n,
  elastic_buffer_skp_ctrl_if.slave bus
);
  localparam int FILL_W = $clog2(BUFFER_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, SKP_OS} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  added;
    logic                  removed;
    logic                  adj;
    logic                  uf;
  } resp_t;

  state_t      state, state_n;
  logic [2:0]  skp_cnt, skp_cnt_n;
  logic        adj_done, adj_n;
  resp_t       resp_q, resp_n;
  logic [1:0]  pop;
  logic        ovf_q;

  logic              is_com, is_skp, next_skp;
  logic [FILL_W-1:0] start_lvl, hi_lvl, fill;

  assign fill      = bus.fill_level;
  assign is_com    = (bus.head_data == COM_N) || (bus.head_data == COM_P);
  assign is_skp    = (bus.head_data == SKP_N) || (bus.head_data == SKP_P);
  assign next_skp  = (bus.head_next_data == SKP_N) || (bus.head_next_data == SKP_P);
  assign start_lvl = bus.buffer_mode ? FILL_W'(1) : FILL_W'(BUFFER_DEPTH / 2);
  assign hi_lvl    = bus.buffer_mode ? FILL_W'(EMPTY_HIGH_WM) : FILL_W'(HIGH_WM);

  always_comb begin
    state_n        = state;
    skp_cnt_n      = skp_cnt;
    adj_n          = adj_done;
    pop            = 2'd0;
    resp_n         = resp_q;
    resp_n.valid   = 1'b0;
    resp_n.added   = 1'b0;
    resp_n.removed = 1'b0;
    resp_n.adj     = 1'b0;
    resp_n.uf      = 1'b0;
    case (state)
      IDLE: if (fill >= start_lvl) state_n = RUN;
      RUN, SKP_OS: begin
        if (fill == '0) begin
          resp_n.uf = 1'b1;
          state_n   = IDLE;
        end else if (state == SKP_OS && is_skp) begin
          resp_n.valid = 1'b1;
          resp_n.data  = bus.head_data;
          // Drop retires the head SKP plus its twin, so one SKP always survives.
          if (!adj_done && fill > hi_lvl && next_skp && fill >= FILL_W'(2)) begin
            pop            = 2'd2;
            resp_n.removed = 1'b1;
            resp_n.adj     = 1'b1;
            adj_n          = 1'b1;
          end else if (!adj_done && !bus.buffer_mode && fill < FILL_W'(LOW_WM)) begin
            pop          = 2'd0;
            resp_n.added = 1'b1;
            resp_n.adj   = 1'b1;
            adj_n        = 1'b1;
          end else begin
            pop = 2'd1;
          end
          skp_cnt_n = skp_cnt + {1'b0, pop};
          if (skp_cnt_n >= 3'd5) state_n = RUN;
        end else begin
          pop          = 2'd1;
          resp_n.valid = 1'b1;
          resp_n.data  = bus.head_data;
          if (is_com) begin
            state_n   = SKP_OS;
            skp_cnt_n = 3'd0;
            adj_n     = 1'b0;
          end else begin
            state_n = RUN;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_read) begin
    if (!rst_n) begin
      state    <= IDLE;
      skp_cnt  <= 3'd0;
      adj_done <= 1'b0;
      resp_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_n;
      skp_cnt  <= skp_cnt_n;
      adj_done <= adj_n;
      resp_q   <= resp_n;
      if (fill == FILL_W'(BUFFER_DEPTH)) ovf_q <= 1'b1;
    end
  end

  assign bus.pop_cnt           = pop;
  assign bus.data_out          = resp_q.data;
  assign bus.out_valid         = resp_q.valid;
  assign bus.skp_added         = resp_q.added;
  assign bus.skp_removed       = resp_q.removed;
  assign bus.skp_added_removed = resp_q.adj;
  assign bus.underflow         = resp_q.uf;
  assign bus.overflow          = ovf_q;
endmodule

// File: tb/tb_elastic_buffer_skp_ctrl.sv
// Directed bench for elastic_buffer_skp_ctrl: symbol stream model on the input
// side, expected-output queue drained by a negedge monitor.
module tb_elastic_buffer_skp_ctrl;
  localparam int DW    = 10;
  localparam int DEPTH = 16;
  localparam logic [DW-1:0] COM    = 10'h0FA;
  localparam logic [DW-1:0] SKP    = 10'h0F4;
  localparam logic [DW-1:0] FILLER = 10'h155;

  typedef struct {
    logic [DW-1:0] data;
    logic          added;
    logic          removed;
  } exp_t;

  logic clk_read = 1'b0;
  logic rst_n    = 1'b0;

  elastic_buffer_skp_ctrl_if #(.DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH)) bus ();

  elastic_buffer_skp_ctrl #(.DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH)) u_dut (
    .clk_read (clk_read),
    .rst_n    (rst_n),
    .bus      (bus.slave)
  );

  always #5 clk_read = ~clk_read;

  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] sq[$];
  exp_t          exp_q[$];
  logic [1:0]    last_pop;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    bus.head_data      = (sq.size() > 0) ? sq[0] : FILLER;
    bus.head_next_data = (sq.size() > 1) ? sq[1] : FILLER;
  endtask

  task automatic push(input logic [DW-1:0] sym);
    sq.push_back(sym);
    refresh();
  endtask

  task automatic expect_out(input logic [DW-1:0] d, input logic a, input logic r);
    exp_t e;
    e.data = d; e.added = a; e.removed = r;
    exp_q.push_back(e);
  endtask

  // Records the pop decision for this cycle, then retires that many symbols.
  task automatic tick();
    @(negedge clk_read);
    last_pop = bus.pop_cnt;
    @(posedge clk_read);
    #1;
    for (int i = 0; i < int'(last_pop); i++)
      if (sq.size() > 0) void'(sq.pop_front());
    refresh();
  endtask

  always @(negedge clk_read) begin
    if (rst_n && bus.out_valid) begin
      if (bus.data_out == FILLER) begin
        chk("filler_flags", {bus.skp_added, bus.skp_removed, bus.skp_added_removed}, 0);
      end else if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got 0x%0h want nothing at %0t", bus.data_out, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("data_out", bus.data_out, e.data);
        chk("adj_flags", {bus.skp_added, bus.skp_removed, bus.skp_added_removed},
            {e.added, e.removed, e.added | e.removed});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.buffer_mode = 1'b0;
    bus.fill_level  = 5'd8;
    refresh();

    // T1 reset
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_pop", last_pop, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_flags", {bus.out_valid, bus.skp_added, bus.skp_removed,
                      bus.skp_added_removed, bus.underflow, bus.overflow}, 0);

    // T2 start threshold
    bus.fill_level = 5'd4;
    rst_n = 1'b1;
    for (int f = 4; f < 8; f++) begin
      bus.fill_level = 5'(f);
      tick();
      chk("t2_idle_pop", last_pop, 0);
    end
    bus.fill_level = 5'd8;
    tick();
    chk("t2_idle_at8", last_pop, 0);
    push(10'h2AA); expect_out(10'h2AA, 0, 0);
    tick();
    chk("t2_run_pop", last_pop, 1);

    // T3 add at low fill
    bus.fill_level = 5'd5;
    push(COM); push(SKP); push(SKP); push(10'h2BB);
    expect_out(COM, 0, 0); expect_out(SKP, 1, 0); expect_out(SKP, 0, 0);
    expect_out(SKP, 0, 0); expect_out(10'h2BB, 0, 0);
    n = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (last_pop == 0) n++; end
    chk("t3_stall_cnt", n, 1);

    // T4 drop at high fill
    bus.fill_level = 5'd12;
    push(COM); push(SKP); push(SKP); push(10'h1CC);
    expect_out(COM, 0, 0); expect_out(SKP, 0, 1); expect_out(10'h1CC, 0, 0);
    n = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (last_pop == 2) n++; end
    chk("t4_pop2_cnt", n, 1);
    // single SKP must survive
    push(COM); push(SKP); push(10'h1CC);
    expect_out(COM, 0, 0); expect_out(SKP, 0, 0); expect_out(10'h1CC, 0, 0);
    n = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (last_pop == 2) n++; end
    chk("t4_single_skp", n, 0);

    // T5 underflow
    bus.fill_level = 5'd0;
    tick();
    chk("t5_pop", last_pop, 0);
    chk("t5_uf", bus.underflow, 1);
    chk("t5_valid", bus.out_valid, 0);
    tick();
    chk("t5_uf_pulse", bus.underflow, 0);
    bus.fill_level = 5'd7;
    tick(); chk("t5_idle7", last_pop, 0);
    tick(); chk("t5_idle7b", last_pop, 0);
    bus.fill_level = 5'd8;
    tick(); chk("t5_idle8", last_pop, 0);
    tick(); chk("t5_resume", last_pop, 1);

    // T6 mode 1 and overflow
    bus.buffer_mode = 1'b1;
    bus.fill_level  = 5'd16;
    tick();
    chk("t6_ovf_set", bus.overflow, 1);
    bus.fill_level = 5'd5;
    push(COM); push(SKP); push(SKP); push(10'h1CC);
    expect_out(COM, 0, 0); expect_out(SKP, 0, 1); expect_out(10'h1CC, 0, 0);
    n = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (last_pop == 2) n++; end
    chk("t6_drop_m1", n, 1);
    bus.fill_level = 5'd3;
    push(COM); push(SKP); push(10'h1CC);
    expect_out(COM, 0, 0); expect_out(SKP, 0, 0); expect_out(10'h1CC, 0, 0);
    n = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (last_pop == 0) n++; end
    chk("t6_no_add", n, 0);
    chk("t6_ovf_sticky", bus.overflow, 1);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("t6_ovf_clr", bus.overflow, 0);
    rst_n = 1'b1;
    tick();
    chk("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
